pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised elastic pipeline stage: the successor to the plain per-stage pipeline register. It carries a SIZE-bit stage bundle whose low CTRL_SIZE bits are the control field, with a valid/ready handshake on both sides. A two-entry skid buffer (main + skid) sustains one transfer per cycle without a combinational ready path from downstream to upstream. Flush turns held instructions into bubbles by zeroing their control field. It sits between any two pipeline stages of the CPU datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- SIZE, 1, total width of the stage bundle; must be ≥ 1.
- CTRL_SIZE, 1, width of the control field at data bits [CTRL_SIZE-1:0]; must satisfy 1 ≤ CTRL_SIZE ≤ SIZE.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-low.
- in_valid_i  in  1  upstream presents a word.
- in_ready_o  out  1  stage can accept a word; driven only from registers.
- data_i  in  SIZE  upstream word.
- flush_i  in  1  convert all held words and any word accepted this cycle into bubbles.
- out_valid_o  out  1  main register holds a word.
- out_ready_i  in  1  downstream accepts.
- data_o  out  SIZE  main register contents.
- count_o  out  2  occupancy, 0..2.

## Operation
- Accept: in_valid_i & in_ready_o. Emit: out_valid_o & out_ready_i.
- in_ready_o = ~skid_valid.
- Main empty: an accepted word loads main.
- Main full and emitting: if the skid is full, skid moves to main and the skid empties. Otherwise an accepted word loads main; with no accept, main empties.
- Main full and not emitting: an accepted word loads the skid.
- Order is strictly FIFO. No word is dropped or duplicated.
- Flush does not alter valid bits. It zeroes [CTRL_SIZE-1:0] of:
  - the word remaining in main;
  - the word moving from skid to main;
  - the word remaining in skid;
  - the word accepted this cycle.
- A word emitted in the flush cycle leaves unmodified, because data_o was already sampled by downstream.
- Upper bits [SIZE-1:CTRL_SIZE] are never modified by flush.
- count_o = main_valid + skid_valid.

## Timing
- Reset (rst_i=0 at an edge) is applied at that edge:
  - out_valid_o=0, data_o=0, skid data=0, skid_valid=0, count_o=0, in_ready_o=1.
  - in_valid_i and flush_i are ignored.
- Reset has priority over flush and handshakes.
- Latency: an accepted word is on data_o with out_valid_o=1 one cycle after the accept edge when the stage was empty. It takes two cycles if it was buffered in the skid.
- Throughput: 1 word/cycle while out_ready_i=1.
- in_ready_o has no combinational dependence on out_ready_i or in_valid_i.
- After out_ready_i falls, the stage absorbs at most one further word. in_ready_o drops the cycle after the skid fills.
- Simultaneous accept and emit with the skid empty: main is replaced and count stays at 1.
- The data_o value is held stable while out_valid_o=1 and out_ready_i=0, except for flush zeroing the control field.

## Configuration
- PIPE_STAGE_PERF_EN defined:
  - Adds outputs stall_cnt_o[15:0] and flush_cnt_o[15:0], both reset to 0 and saturating at 16'hFFFF.
  - stall_cnt_o increments each cycle with out_valid_o=1 and out_ready_i=0.
  - flush_cnt_o increments each cycle with flush_i=1.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset with SIZE=8, CTRL_SIZE=2: hold rst_i=0 for 2 cycles with in_valid_i=1 and data_i=8'hFF. Require out_valid_o=0, data_o=0, count_o=0, in_ready_o=1; no word is accepted.
- Streaming: send 8'h01..8'h10 back-to-back with out_ready_i=1. Require data_o to follow 1 cycle behind, count_o=1 throughout, and no bubbles.
- Backpressure: stream 8'hA1, 8'hA2, 8'hA3 and drop out_ready_i after A1 is visible.
  - Require A2 absorbed into the skid, in_ready_o=0 the next cycle, count_o=2, and A3 held upstream.
  - Re-raise out_ready_i. Require output order A1, A2, A3.
- Flush while full: main=8'hF7, skid=8'hEB, out_ready_i=0, pulse flush_i. Require main=8'hF4, skid=8'hE8, and valids unchanged.
- Flush with emit and accept: main=8'h37 emitting, skid empty, accept 8'h5B with flush_i=1. Require 8'h37 observed unmodified, then data_o=8'h58.
- PIPE_STAGE_PERF_EN: hold out_ready_i=0 with out_valid_o=1 for 70000 cycles. Require stall_cnt_o=16'hFFFF, and 3 flush pulses give flush_cnt_o=3.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline stage with a main + skid register pair and flush-to-bubble.
// Ports: clk_i/rst_i (sync, active-low), in_valid_i/in_ready_o/data_i upstream,
// out_valid_o/out_ready_i/data_o downstream, flush_i zeroes held control fields,
// count_o occupancy. Define PIPE_STAGE_PERF_EN to add stall_cnt_o/flush_cnt_o.
module pipe_stage_skid #(
  parameter int SIZE      = 1,
  parameter int CTRL_SIZE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [SIZE-1:0] data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [SIZE-1:0] data_o,
  output logic [1:0]      count_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]     stall_cnt_o,
  output logic [15:0]     flush_cnt_o
`endif
);
  localparam logic [SIZE-1:0] CTRL_MASK = {SIZE{1'b1}} >> (SIZE - CTRL_SIZE);
  logic            main_valid, skid_valid, main_valid_n, skid_valid_n;
  logic [SIZE-1:0] main_data, skid_data, main_data_n, skid_data_n, keep;
  logic            accept, emit, in_to_main, in_to_skid, skid_to_main;
  assign in_ready_o  = ~skid_valid;
  assign out_valid_o = main_valid;
  assign data_o      = main_data;
  assign count_o     = {1'b0, main_valid} + {1'b0, skid_valid};
  assign keep        = flush_i ? ~CTRL_MASK : {SIZE{1'b1}};
  assign accept      = in_valid_i & ~skid_valid;
  assign emit        = main_valid & out_ready_i;
  always_comb begin
    in_to_main   = accept & (~main_valid | out_ready_i);
    in_to_skid   = accept & main_valid & ~out_ready_i;
    skid_to_main = emit & skid_valid;
    main_valid_n = skid_to_main | in_to_main | (main_valid & ~out_ready_i);
    skid_valid_n = in_to_skid | (skid_valid & ~emit);
    main_data_n  = (skid_to_main ? skid_data : in_to_main ? data_i : main_data) & keep;
    skid_data_n  = (in_to_skid ? data_i : skid_data) & keep;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      main_data  <= main_data_n;
      skid_data  <= skid_data_n;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (main_valid & ~out_ready_i & ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 16'd1;
      if (flush_i & ~&flush_cnt_o) flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end
`endif
endmodule
